counter_scan_display: RTL and testbench

- Downstream consumer of the 4-bit up/down counter (outputs QD..QA and carry Qcc).
- Shows the live counter nibble as a hex digit on a 4-digit common-anode 7-segment display.
- Counts counter carry/borrow events in a 3-digit BCD overflow register and shows it on the upper three digits.
- Time-multiplexes all four digits from the same CP clock that drives the counter.

---
 rtl/counter_scan_display.sv | 111 +++++++++++
 tb/tb_counter_scan_display.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_scan_display.sv
// counter_scan_display: shows a 4-bit counter nibble and a BCD carry/borrow event count on a 4-digit 7-segment display
//   CP, CLR         rising-edge clock shared with the counter, asynchronous active-low reset
//   QD..QA          counter value (QD = MSB), shown as a hex digit on digit 0
//   Qcc             counter ripple carry/borrow, active-low; each falling edge is one event
//   M               counter direction (1 = up): selects BCD increment/decrement, lights DP in down mode
//   SEG, AN, DP     active-low segments {g,f,e,d,c,b,a}, one-hot digit enables (AN[0] rightmost), decimal point
//   OVF             BCD event count {hundreds, tens, units}, shown on digits 3..1
module counter_scan_display #(
   parameter int SCAN_DIV = 16,
   parameter int BLANK_LZ = 1
) (
   input  logic        CP,
   input  logic        CLR,
   input  logic        QD,
   input  logic        QC,
   input  logic        QB,
   input  logic        QA,
   input  logic        Qcc,
   input  logic        M,
   output logic [6:0]  SEG,
   output logic [3:0]  AN,
   output logic        DP,
   output logic [11:0] OVF
);
   localparam int DW = $clog2(SCAN_DIV);

   logic          r_qcc_q;
   logic [11:0]   r_ovf;
   logic [DW-1:0] r_div;
   logic [1:0]    r_idx;
   logic [3:0]    r_an;
   logic [6:0]    r_seg;
   logic          r_dp;
   logic          w_evt;
   logic [3:0]    w_u, w_t, w_h;
   logic [11:0]   w_inc, w_dec;
   logic [3:0]    w_dig;
   logic          w_blank;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   // falling edge of the active-low carry; history clears on reset so a low Qcc at release is not an event
   assign w_evt = r_qcc_q & ~Qcc;
   assign {w_h, w_t, w_u} = r_ovf;

   // per-digit carry/borrow ripples only while lower digits sit at their wrap value
   assign w_inc[3:0]  = (w_u == 4'd9) ? 4'd0 : w_u + 4'd1;
   assign w_inc[7:4]  = (w_u != 4'd9) ? w_t : (w_t == 4'd9) ? 4'd0 : w_t + 4'd1;
   assign w_inc[11:8] = (w_u != 4'd9 || w_t != 4'd9) ? w_h : (w_h == 4'd9) ? 4'd0 : w_h + 4'd1;
   assign w_dec[3:0]  = (w_u == 4'd0) ? 4'd9 : w_u - 4'd1;
   assign w_dec[7:4]  = (w_u != 4'd0) ? w_t : (w_t == 4'd0) ? 4'd9 : w_t - 4'd1;
   assign w_dec[11:8] = (w_u != 4'd0 || w_t != 4'd0) ? w_h : (w_h == 4'd0) ? 4'd9 : w_h - 4'd1;

   // digit 0 reads the counter inputs directly so a count change shows within one cycle
   assign w_dig = (r_idx == 2'd0) ? {QD, QC, QB, QA} :
                  (r_idx == 2'd1) ? w_u :
                  (r_idx == 2'd2) ? w_t : w_h;

   assign w_blank = (BLANK_LZ != 0) &&
                    ((r_idx == 2'd1 && r_ovf == 12'h000) ||
                     (r_idx == 2'd2 && r_ovf[11:4] == 8'h00) ||
                     (r_idx == 2'd3 && w_h == 4'd0));

   always_ff @(posedge CP or negedge CLR) begin
      if (!CLR) begin
         r_qcc_q <= 1'b0;
         r_ovf   <= 12'h000;
         r_div   <= '0;
         r_idx   <= 2'd0;
         r_an    <= 4'b1111;
         r_seg   <= 7'b1111111;
         r_dp    <= 1'b1;
      end else begin
         r_qcc_q <= Qcc;
         if (w_evt) r_ovf <= M ? w_inc : w_dec;
         if (r_div == DW'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
         end else begin
            r_div <= r_div + DW'(1);
         end
         r_an  <= ~(4'b0001 << r_idx);
         r_seg <= w_blank ? 7'b1111111 : seg7(w_dig);
         r_dp  <= !(r_idx == 2'd0 && !M);
      end
   end

   assign SEG = r_seg;
   assign AN  = r_an;
   assign DP  = r_dp;
   assign OVF = r_ovf;
endmodule

// File: tb/tb_counter_scan_display.sv
// tb_counter_scan_display: scoreboard bench for counter_scan_display with SCAN_DIV=4
module tb_counter_scan_display;
   logic        CP = 1'b0;
   logic        CLR = 1'b0;
   logic        QD = 1'b0, QC = 1'b0, QB = 1'b0, QA = 1'b0;
   logic        Qcc = 1'b1;
   logic        M = 1'b1;
   logic [6:0]  SEG;
   logic [3:0]  AN;
   logic        DP;
   logic [11:0] OVF;

   int checks = 0;
   int failures = 0;

   // expected {AN, SEG, DP, OVF}, pushed as each cycle is driven, popped after the edge
   logic [23:0] sb[$];

   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   int         m_val;
   logic       m_qcc_q;
   int         m_div;
   logic [1:0] m_idx;

   counter_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
      .CP(CP), .CLR(CLR), .QD(QD), .QC(QC), .QB(QB), .QA(QA),
      .Qcc(Qcc), .M(M), .SEG(SEG), .AN(AN), .DP(DP), .OVF(OVF)
   );

   always #5 CP = ~CP;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      m_val = 0;
      m_qcc_q = 1'b0;
      m_div = 0;
      m_idx = 2'd0;
      sb.delete();
   endtask

   // drives one cycle, predicts the registered outputs after the next rising edge, then waits past it
   task automatic drive_cycle(input logic [3:0] q, input logic qcc, input logic m);
      logic [3:0] an;
      logic [3:0] d;
      logic       bl;
      logic [6:0] sg;
      {QD, QC, QB, QA} = q;
      Qcc = qcc;
      M = m;
      an = 4'b1111;
      an[m_idx] = 1'b0;
      d = (m_idx == 2'd0) ? q : (m_idx == 2'd1) ? 4'(m_val % 10) :
          (m_idx == 2'd2) ? 4'((m_val / 10) % 10) : 4'(m_val / 100);
      bl = (m_idx == 2'd1) ? (m_val == 0) : (m_idx == 2'd2) ? (m_val < 10) :
           (m_idx == 2'd3) ? (m_val < 100) : 1'b0;
      sg = bl ? 7'b1111111 : seg_tab[d];
      if (m_qcc_q && !qcc) m_val = m ? (m_val + 1) % 1000 : (m_val + 999) % 1000;
      m_qcc_q = qcc;
      if (m_div == 3) begin
         m_div = 0;
         m_idx = m_idx + 2'd1;
      end else begin
         m_div = m_div + 1;
      end
      sb.push_back({an, sg, !(an == 4'b1110 && !m), to_bcd(m_val)});
      @(posedge CP);
      #1;
   endtask

   task automatic test_reset();
      CLR = 1'b0;
      #12;
      model_reset();
      checks++;
      if (AN !== 4'b1111) begin failures++; $display("FAIL reset_an got %b exp 1111", AN); end
      checks++;
      if (SEG !== 7'b1111111) begin failures++; $display("FAIL reset_seg got %b exp 1111111", SEG); end
      checks++;
      if (DP !== 1'b1) begin failures++; $display("FAIL reset_dp got %b exp 1", DP); end
      checks++;
      if (OVF !== 12'h000) begin failures++; $display("FAIL reset_ovf got %h exp 000", OVF); end
   endtask

   task automatic test_scan();
      logic [23:0] exp;
      CLR = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive_cycle(4'b0100, 1'b1, 1'b1);
         exp = sb.pop_front();
         checks++;
         if ({AN, SEG, DP, OVF} !== exp) begin
            failures++;
            $display("FAIL scan cyc %0d got AN=%b SEG=%b DP=%b OVF=%h exp %h", i, AN, SEG, DP, OVF, exp);
         end
         if (i < 4) begin
            checks++;
            if (AN !== 4'b1110 || SEG !== 7'b0011001) begin
               failures++;
               $display("FAIL scan_digit0 cyc %0d got AN=%b SEG=%b exp 1110/0011001", i, AN, SEG);
            end
         end
      end
   endtask

   task automatic test_hex_digit();
      logic [23:0] exp;
      for (int i = 0; i < 256; i++) begin
         drive_cycle(4'(i / 16), 1'b1, 1'b1);
         exp = sb.pop_front();
         checks++;
         if ({AN, SEG, DP, OVF} !== exp) begin
            failures++;
            $display("FAIL hex cyc %0d got AN=%b SEG=%b DP=%b OVF=%h exp %h", i, AN, SEG, DP, OVF, exp);
         end
      end
   endtask

   task automatic test_carry_pulse();
      logic [23:0] exp;
      for (int i = 0; i < 18; i++) begin
         drive_cycle(4'h3, (i == 1) ? 1'b0 : 1'b1, 1'b1);
         exp = sb.pop_front();
         checks++;
         if ({AN, SEG, DP, OVF} !== exp) begin
            failures++;
            $display("FAIL pulse cyc %0d got AN=%b SEG=%b DP=%b OVF=%h exp %h", i, AN, SEG, DP, OVF, exp);
         end
         if (i == 1) begin
            checks++;
            if (OVF !== 12'h001) begin failures++; $display("FAIL pulse_ovf got %h exp 001", OVF); end
         end
         if (AN == 4'b1101) begin
            checks++;
            if (SEG !== 7'b1111001) begin failures++; $display("FAIL pulse_digit1 got %b exp 1111001", SEG); end
         end
      end
   endtask

   task automatic test_hold_low();
      logic [23:0] exp;
      for (int i = 0; i < 8; i++) begin
         drive_cycle(4'h9, (i >= 1 && i <= 5) ? 1'b0 : 1'b1, 1'b1);
         exp = sb.pop_front();
         checks++;
         if ({AN, SEG, DP, OVF} !== exp) begin
            failures++;
            $display("FAIL hold cyc %0d got AN=%b SEG=%b DP=%b OVF=%h exp %h", i, AN, SEG, DP, OVF, exp);
         end
      end
      checks++;
      if (OVF !== 12'h002) begin failures++; $display("FAIL hold_ovf got %h exp 002", OVF); end
   endtask

   task automatic test_wrap_up();
      logic [23:0] exp;
      int guard = 0;
      while (m_val != 999 && guard < 1200) begin
         guard++;
         for (int p = 0; p < 2; p++) begin
            drive_cycle(4'hA, p[0], 1'b1);
            exp = sb.pop_front();
            checks++;
            if ({AN, SEG, DP, OVF} !== exp) begin
               failures++;
               $display("FAIL fill ev %0d got AN=%b SEG=%b DP=%b OVF=%h exp %h", guard, AN, SEG, DP, OVF, exp);
            end
         end
      end
      checks++;
      if (OVF !== 12'h999) begin failures++; $display("FAIL fill_ovf got %h exp 999", OVF); end
      for (int i = 0; i < 18; i++) begin
         drive_cycle(4'hB, (i == 1) ? 1'b0 : 1'b1, 1'b1);
         exp = sb.pop_front();
         checks++;
         if ({AN, SEG, DP, OVF} !== exp) begin
            failures++;
            $display("FAIL wrap_up cyc %0d got AN=%b SEG=%b DP=%b OVF=%h exp %h", i, AN, SEG, DP, OVF, exp);
         end
         if (i == 1) begin
            checks++;
            if (OVF !== 12'h000) begin failures++; $display("FAIL wrap_up_ovf got %h exp 000", OVF); end
         end
      end
   endtask

   task automatic test_wrap_down();
      logic [23:0] exp;
      for (int i = 0; i < 20; i++) begin
         drive_cycle(4'hC, (i == 1) ? 1'b0 : 1'b1, 1'b0);
         exp = sb.pop_front();
         checks++;
         if ({AN, SEG, DP, OVF} !== exp) begin
            failures++;
            $display("FAIL wrap_down cyc %0d got AN=%b SEG=%b DP=%b OVF=%h exp %h", i, AN, SEG, DP, OVF, exp);
         end
         if (i == 1) begin
            checks++;
            if (OVF !== 12'h999) begin failures++; $display("FAIL wrap_down_ovf got %h exp 999", OVF); end
         end
         if (AN == 4'b1110) begin
            checks++;
            if (DP !== 1'b0) begin failures++; $display("FAIL down_dp got %b exp 0", DP); end
         end else if (i > 1) begin
            checks++;
            if (SEG !== 7'b0010000) begin failures++; $display("FAIL down_nine got %b exp 0010000", SEG); end
         end
      end
   endtask

   task automatic test_async_reset();
      logic [23:0] exp;
      int guard = 0;
      bit found = 0;
      while (m_val != 57 && guard < 200) begin
         guard++;
         for (int p = 0; p < 2; p++) begin
            drive_cycle(4'h5, p[0], 1'b1);
            exp = sb.pop_front();
            checks++;
            if ({AN, SEG, DP, OVF} !== exp) begin
               failures++;
               $display("FAIL to57 ev %0d got AN=%b SEG=%b DP=%b OVF=%h exp %h", guard, AN, SEG, DP, OVF, exp);
            end
         end
      end
      for (int i = 0; i < 32 && !found; i++) begin
         drive_cycle(4'h5, 1'b1, 1'b1);
         exp = sb.pop_front();
         checks++;
         if ({AN, SEG, DP, OVF} !== exp) begin
            failures++;
            $display("FAIL seek cyc %0d got AN=%b SEG=%b DP=%b OVF=%h exp %h", i, AN, SEG, DP, OVF, exp);
         end
         found = (AN == 4'b1011);
      end
      checks++;
      if (!found || OVF !== 12'h057) begin
         failures++;
         $display("FAIL seek_1011 got AN=%b OVF=%h exp 1011/057", AN, OVF);
      end
      #2 CLR = 1'b0;
      #1;
      checks++;
      if ({AN, SEG, DP, OVF} !== {4'b1111, 7'b1111111, 1'b1, 12'h000}) begin
         failures++;
         $display("FAIL async_clr got AN=%b SEG=%b DP=%b OVF=%h exp 1111/1111111/1/000", AN, SEG, DP, OVF);
      end
      #1 CLR = 1'b1;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         drive_cycle(4'h6, (i < 2) ? 1'b0 : 1'b1, 1'b1);
         exp = sb.pop_front();
         checks++;
         if ({AN, SEG, DP, OVF} !== exp) begin
            failures++;
            $display("FAIL release cyc %0d got AN=%b SEG=%b DP=%b OVF=%h exp %h", i, AN, SEG, DP, OVF, exp);
         end
         if (i == 0) begin
            checks++;
            if (AN !== 4'b1110) begin failures++; $display("FAIL release_an got %b exp 1110", AN); end
         end
      end
      checks++;
      if (OVF !== 12'h000) begin failures++; $display("FAIL release_low_qcc got %h exp 000", OVF); end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_hex_digit();
      test_carry_pulse();
      test_hold_low();
      test_wrap_up();
      test_wrap_down();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
